// File: rtl/seq_shift_unit_if.sv
// Request/response bundle for seq_shift_unit.
// The master side is the producer and consumer in the datapath. The slave side is the shift unit.
interface seq_shift_unit_if #(
    parameter int WIDTH = 16
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   shamt;
    logic [1:0]       op;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;

    modport master (
        output in_valid, a, shamt, op, flush, out_ready,
        input  in_ready, out_valid, result, carry, zero
    );

    modport slave (
        input  in_valid, a, shamt, op, flush, out_ready,
        output in_ready, out_valid, result, carry, zero
    );
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit that moves one bit position per clock.
// It supports SLL, SRL, SRA and ROR, with carry-out and zero flags.
module seq_shift_unit #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_shift_unit_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_shifted;
    logic             r_carry;
    logic             w_shift_carry;
    logic [SHW-1:0]   r_count;
    logic [1:0]       r_op;
    logic             w_accept;
    logic             w_step;

    assign w_accept = (r_state == IDLE) && bus.in_valid && !bus.flush;
    assign w_step   = (r_state == SHIFT) && !bus.flush;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush overrides every other transition
    always_comb begin
        w_next = r_state;
        if (bus.flush) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (bus.in_valid) w_next = (bus.shamt == '0) ? DONE : SHIFT;
                SHIFT:   if (r_count == SHW'(1)) w_next = DONE;
                DONE:    if (bus.out_ready) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // One-bit step of the selected operation and the bit it pushes out
    always_comb begin
        w_shifted     = r_result;
        w_shift_carry = 1'b0;
        unique case (op_t'(r_op))
            OP_SLL: begin
                w_shifted     = {r_result[WIDTH-2:0], 1'b0};
                w_shift_carry = r_result[WIDTH-1];
            end
            OP_SRL: begin
                w_shifted     = {1'b0, r_result[WIDTH-1:1]};
                w_shift_carry = r_result[0];
            end
            OP_SRA: begin
                w_shifted     = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
                w_shift_carry = r_result[0];
            end
            OP_ROR: begin
                w_shifted     = {r_result[0], r_result[WIDTH-1:1]};
                w_shift_carry = r_result[0];
            end
            default: begin
                w_shifted     = r_result;
                w_shift_carry = 1'b0;
            end
        endcase
    end

    // Operand capture on accept, then one step per SHIFT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            r_op     <= '0;
        end else if (w_accept) begin
            r_result <= bus.a;
            r_op     <= bus.op;
            r_count  <= bus.shamt;
            r_carry  <= 1'b0;
        end else if (w_step) begin
            r_result <= w_shifted;
            r_carry  <= w_shift_carry;
            r_count  <= r_count - SHW'(1);
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.carry     = r_carry;
    // Gating with DONE keeps zero low out of reset while still tracking result when valid
    assign bus.zero      = (r_state == DONE) && (r_result == '0);
endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed self-checking bench for seq_shift_unit (WIDTH=16).
module tb_seq_shift_unit;
    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    seq_shift_unit_if #(.WIDTH(16)) bus ();

    seq_shift_unit #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, presents one request, and then scrambles the inputs after the accept edge.
    task automatic do_req(input logic [1:0] op, input logic [15:0] a, input logic [3:0] s);
        int unsigned n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("req_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.shamt    = s;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.op       = ~op;
        bus.shamt    = ~s;
        check("accepted_in_ready_low", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (lat >= 100) check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                          input logic [3:0] s, input logic [15:0] exp_r, input logic exp_c);
        int lat;
        do_req(op, a, s);
        wait_out(lat);
        check({tag, "_latency"}, 32'(lat), 32'(s));
        check({tag, "_result"}, 32'(bus.result), 32'(exp_r));
        check({tag, "_carry"}, 32'(bus.carry), 32'(exp_c));
        check({tag, "_zero"}, 32'(bus.zero), (exp_r == 16'h0) ? 32'd1 : 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_post_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int  lat;
        logic seen;
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.shamt     = '0;
        bus.op        = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_carry", 32'(bus.carry), 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd0);
        #9 rst_n = 1'b1;
        tick();

        run_op("sra_1",   SRA, 16'h8E8E, 4'd1,  16'hC747, 1'b0);
        run_op("srl_15",  SRL, 16'h8002, 4'd15, 16'h0001, 1'b0);
        run_op("sra_15",  SRA, 16'h8002, 4'd15, 16'hFFFF, 1'b0);
        run_op("sll_1",   SLL, 16'h8001, 4'd1,  16'h0002, 1'b1);
        run_op("ror_4",   ROR, 16'h0001, 4'd4,  16'h1000, 1'b0);
        run_op("sll_zero", SLL, 16'h8000, 4'd1, 16'h0000, 1'b1);

        // Back-pressure: the result stays in DONE while in_valid pulses are ignored
        do_req(ROR, 16'h00F1, 4'd1);
        wait_out(lat);
        check("bp_latency", 32'(lat), 32'd1);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.a        = 16'h5555;
            bus.shamt    = 4'd0;
            tick();
            check("bp_result", 32'(bus.result), 32'h8078);
            check("bp_carry", 32'(bus.carry), 32'd1);
            check("bp_zero", 32'(bus.zero), 32'd0);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_handoff_valid", 32'(bus.out_valid), 32'd0);
        check("bp_handoff_ready", 32'(bus.in_ready), 32'd1);
        run_op("after_bp", SRL, 16'hF000, 4'd12, 16'h000F, 1'b0);

        // Flush asserted in the third SHIFT cycle
        do_req(SRA, 16'hF000, 4'd8);
        tick();
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        check("flush_no_result", 32'(seen), 32'd0);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.a        = 16'h1234;
        bus.shamt    = 4'd3;
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check("flush_blocks_accept", 32'(bus.in_ready), 32'd1);
        run_op("post_flush", SRL, 16'h0F00, 4'd4, 16'h00F0, 1'b0);

        // Asynchronous reset in the middle of a shift
        do_req(SLL, 16'h1234, 4'd10);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_result", 32'(bus.result), 32'd0);
        check("mid_rst_carry", 32'(bus.carry), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op("shamt0", SRA, 16'hBEEF, 4'd0, 16'hBEEF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seq_shift_unit.md
# seq_shift_unit

Multi-cycle, parametrised shift/rotate unit for the CPU datapath. It generalises the combinational 16-bit arithmetic right shifter to any power-of-two width. It supports four modes (SLL, SRL, SRA, ROR) and shifts one bit position per clock. It sits between the register-read stage and writeback behind a valid/ready handshake, and reports carry-out and zero flags with each result.

## Interface
- WIDTH, 16, operand/result width; power of two, ≥ 4
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand/op/shamt valid
- in_ready  output  1  unit can accept a request
- a  input  WIDTH  operand
- shamt  input  SHW  shift amount, 0..WIDTH-1
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- flush  input  1  synchronous abort; discards any in-flight request
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  shifted value
- carry  output  1  last bit shifted or rotated out
- zero  output  1  result == 0

## Operation
- The FSM has three states: IDLE, SHIFT, DONE. Reset enters IDLE.
- Reset values: in_ready=1, out_valid=0, result=0, carry=0, zero=0. Internal count=0, op register=0.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- **Accept** (IDLE, in_valid=1, flush=0):
  - Register a, op and count=shamt; clear carry.
  - Go to DONE if shamt==0, otherwise go to SHIFT.
- **SHIFT**: each edge shifts the working register by exactly one bit and decrements count.
  - SLL: result<<1, zero fill, carry←old MSB.
  - SRL: result>>1, zero fill, carry←old LSB.
  - SRA: result>>1, MSB replicated, carry←old LSB.
  - ROR: rotate right by 1, old LSB→MSB, carry←old LSB.
  - When count reaches 0 after the decrement (i.e., on the edge where count was 1), go to DONE.
- **DONE**: result, carry and zero are held stable until out_ready=1. Then go to IDLE.
- zero is combinational from result, or registered alongside it. Either way it must equal (result==0) whenever out_valid=1.
- Boundary behaviour:
  - shamt=0: result=a, carry=0.
  - shamt=WIDTH-1 is the maximum; there is no wrap.
- **flush**:
  - Has highest priority below reset. In any state it returns to IDLE on the next edge.
  - out_valid drops and the in-flight result is discarded.
  - A request presented with flush=1 is not accepted.
- in_valid while not in IDLE is ignored (in_ready=0). The producer must hold its request.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronous), and no result is produced.
- Sampled a/op/shamt changing after acceptance has no effect.

## Timing
- Request accepted on edge E0, where in_valid & in_ready are both high.
- out_valid rises after edge E(shamt): shamt cycles after E0 for shamt ≥ 1, or directly after E0 for shamt=0.
- Result handoff on the edge where out_valid & out_ready are both high. in_ready rises in the following cycle, so there is one bubble cycle between back-to-back requests.
- Throughput: one result per shamt+2 cycles with out_ready tied high (minimum 2 for shamt=0).
- No combinational path from in_valid or out_ready to any output other than through state. in_ready and out_valid are purely state-decoded.

## Test plan
- WIDTH=16, SRA, a=0x8E8E, shamt=1 -> result=0xC747, carry=0, zero=0; out_valid one cycle after acceptance.
- SRL, a=0x8002, shamt=15 -> result=0x0001, carry=0. out_valid exactly 15 cycles after acceptance. SRA with the same inputs -> result=0xFFFF.
- SLL, a=0x8001, shamt=1 -> result=0x0002, carry=1. ROR, a=0x0001, shamt=4 -> result=0x1000, carry=0. SLL, a=0x8000, shamt=1 -> result=0x0000, zero=1, carry=1.
- Back-pressure: hold out_ready=0 for 3 cycles in DONE -> result/carry/zero stable, in_ready=0, in_valid pulses ignored. The next request is accepted only after handoff plus one cycle.
- flush asserted in the 3rd SHIFT cycle of SRA a=0xF000, shamt=8 -> IDLE next edge, out_valid never rises. The next request, a=0x0F00, SRL, shamt=4, returns 0x00F0.
- rst_n pulled low mid-SHIFT -> in_ready=1, out_valid=0, result=0 immediately. After release, a shamt=0 request returns a unchanged, with carry=0.
